// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM state type, default bus widths and the
// UART register block address map (also used by the slave side).
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 12;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    // UART register block map
    localparam logic [APB_ADDR_W-1:0] UART_TX_DATA = 12'h000;
    localparam logic [APB_ADDR_W-1:0] UART_RX_DATA = 12'h004;
    localparam logic [APB_ADDR_W-1:0] UART_CFG     = 12'h008;
    localparam logic [APB_ADDR_W-1:0] UART_CTRL    = 12'h00C;
    localparam logic [APB_ADDR_W-1:0] UART_STT     = 12'h010;

    // Word alignment check on the two address LSBs
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter for the APB master.
// Ports:
//   clk, reset_n  clock / async active-low reset
//   clear_i       synchronous clear (takes priority over enable_i)
//   enable_i      count one wait cycle
//   expired_o     count has reached TIMEOUT-1; constant 0 when TIMEOUT == 0
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    if (TIMEOUT == 0) begin : g_no_timeout
        logic unused_inputs;
        assign unused_inputs = ^{clk, reset_n, clear_i, enable_i};
        assign expired_o     = 1'b0;
    end else begin : g_timeout
        logic [CNT_W-1:0] count_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                count_q <= '0;
            end else if (clear_i) begin
                count_q <= '0;
            end else if (enable_i) begin
                count_q <= count_q + 1'b1;
            end
        end

        assign expired_o = (count_q == CNT_W'(TIMEOUT - 1));
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB3/4 initiator: turns single host commands (valid/ready) into one
// SETUP/ACCESS transfer and returns data/error on a valid/ready response
// channel. One transfer outstanding at a time.
// Ports:
//   clk, reset_n                      clock / async active-low reset
//   cmd_valid_i/cmd_ready_o           command handshake
//   cmd_write_i, cmd_addr_i,
//   cmd_wdata_i, cmd_strb_i           command payload
//   rsp_valid_o/rsp_ready_i           response handshake
//   rsp_rdata_o, rsp_error_o,
//   rsp_timeout_o                     response payload
//   busy_o                            transfer in progress
//   psel_o, penable_o, pwrite_o,
//   paddr_o, pwdata_o, pstrb_o        APB request
//   prdata_i, pready_i, pslverr_i     APB completion
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W/8-1:0] cmd_strb_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_error_o,
    output logic                rsp_timeout_o,
    output logic                busy_o,
    output logic                psel_o,
    output logic                penable_o,
    output logic                pwrite_o,
    output logic [ADDR_W-1:0]   paddr_o,
    output logic [DATA_W-1:0]   pwdata_o,
    output logic [DATA_W/8-1:0] pstrb_o,
    input  logic [DATA_W-1:0]   prdata_i,
    input  logic                pready_i,
    input  logic                pslverr_i
);

    localparam int unsigned STRB_W = DATA_W / 8;

    apb_mst_state_e state_q, state_d;

    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [STRB_W-1:0] pstrb_q;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic load_cmd;
    logic load_rsp;
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (timer_clear),
        .enable_i  (timer_enable),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        load_cmd      = 1'b0;
        load_rsp      = 1'b0;
        rsp_rdata_d   = '0;
        rsp_error_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        timer_clear   = 1'b0;
        timer_enable  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (is_word_aligned(cmd_addr_i[1:0])) begin
                        load_cmd = 1'b1;
                        state_d  = SETUP;
                    end else begin
                        // Misaligned: answer with an error, bus untouched
                        load_rsp    = 1'b1;
                        rsp_error_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            SETUP: begin
                timer_clear = 1'b1;
                state_d     = ACCESS;
            end
            ACCESS: begin
                // pready has priority over an expiring timer on the same cycle
                if (pready_i) begin
                    load_rsp    = 1'b1;
                    rsp_error_d = pslverr_i;
                    rsp_rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
                    state_d     = RESP;
                end else if (timer_expired) begin
                    load_rsp      = 1'b1;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    timer_enable = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_cmd) begin
                paddr_q  <= cmd_addr_i;
                pwrite_q <= cmd_write_i;
                // Reads present zero data and strobes on the bus
                pwdata_q <= cmd_write_i ? cmd_wdata_i : '0;
                pstrb_q  <= cmd_write_i ? cmd_strb_i : '0;
            end
            if (load_rsp) begin
                rsp_rdata_q   <= rsp_rdata_d;
                rsp_error_q   <= rsp_error_d;
                rsp_timeout_q <= rsp_timeout_d;
            end
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign psel_o        = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o     = (state_q == ACCESS);
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;
    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_error_o   = rsp_error_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule
